sprite_fetch_scheduler: RTL and testbench
=========================================

Name: sprite_fetch_scheduler

Overview:
Sequences frame-consistent reads of the sprite coordinate words (mario/player X/Y) from the VGA read port (port A) of basic_mem. On a start-of-vblank pulse from the vga block, it walks NUM_WORDS addresses at a fixed stride and captures each word into shadow registers. It then commits all words atomically to the coordinate outputs that drive vga. This removes tearing and the combinational latch-style sequencing from the top level.

Parameters:
WIDTH, 16, data word width
ADDR_BITS, 16, memory address width
NUM_WORDS, 6, coordinate words per frame; order is mx,my,p1x,p1y,p2x,p2y
BASE_ADDR, 6000, address of word 0
ADDR_STRIDE, 4, address increment between words
READ_LATENCY, 1, cycles from address presented to mem_data valid; must be >=1
H_RES, 640, horizontal resolution, used only by the optional clamp
V_RES, 480, vertical resolution, used only by the optional clamp

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_start  input  1  single-cycle pulse at vblank start
mem_addr  output  ADDR_BITS  port A address
mem_rd_en  output  1  high for the single issue cycle of each read
mem_data  input  WIDTH  port A read data
coords  output  NUM_WORDS*WIDTH  committed words; word k occupies bits [k*WIDTH +: WIDTH]
busy  output  1  fetch in progress
frame_done  output  1  one-cycle pulse during COMMIT
overrun  output  1  sticky; frame_start seen while busy

Behaviour:
- Reset (async, active-high): state=IDLE, idx=0, shadow=0, coords=0, mem_rd_en=0, frame_done=0, overrun=0, busy=0.
- mem_addr = BASE_ADDR + idx*ADDR_STRIDE, truncated to ADDR_BITS. Its value in IDLE is BASE_ADDR.
- FSM states: IDLE, REQ, WAIT, CAPTURE, COMMIT. busy=1 in every state except IDLE.
- IDLE: frame_start=1 -> REQ with idx=0.
- REQ (one cycle): mem_rd_en=1. Goes to WAIT if READ_LATENCY>1, else to CAPTURE.
- WAIT: lasts READ_LATENCY-1 cycles, counted by a down-counter, then goes to CAPTURE.
- CAPTURE: CAPTURE occurs exactly READ_LATENCY cycles after REQ. shadow[idx] <= mem_data on the clock edge ending CAPTURE.
  - If idx==NUM_WORDS-1 -> COMMIT.
  - Else idx++ and go to REQ.
- COMMIT (one cycle): frame_done=1. coords <= shadow, all words on the same edge. idx <= 0. Next state is IDLE.
- Timing: take frame_start sampled at edge E0 as the reference.
  - REQ of word k occurs in cycle k*(READ_LATENCY+1)+1.
  - COMMIT occurs in cycle NUM_WORDS*(READ_LATENCY+1)+1, which is 13 with the default parameters.
  - coords are valid from cycle 14 onward.
- coords change only at COMMIT and never show a partial frame.
- frame_start while busy (including during COMMIT): ignored, and overrun <= 1. overrun is cleared only by reset.
- A frame_start held high for multiple cycles while IDLE starts a single fetch. The remaining high cycles count as overrun.
- Reset mid-fetch: abort immediately and return to reset values. The previously committed coords are lost (set to 0).
- mem_data is sampled only in CAPTURE. Its value at all other times is don't-care.

Optional Feature:
Macro SPRITE_FETCH_CLAMP_EN.
- Defined: in CAPTURE, each word is treated as unsigned and clamped before it is stored in shadow.
  - Even idx (X words) saturates to H_RES-1.
  - Odd idx (Y words) saturates to V_RES-1.
- Undefined: raw mem_data is stored unchanged. H_RES and V_RES are unused.

Test Plan:
1. Memory words at 6000, 6004, 6008, 6012, 6016, 6020 hold 10, 20, 30, 40, 50, 60. Pulse frame_start once.
   -> mem_rd_en is high in cycles 1, 3, 5, 7, 9, 11 with addresses 6000 through 6020.
   -> frame_done is high in cycle 13.
   -> coords = {60, 50, 40, 30, 20, 10}, with word 0 in the LSBs. busy=0 from cycle 14.
2. After test 1 commits, write 99 to address 6000 and complete a second fetch.
   -> coords word0 stays 10 up to and including cycle 13 of the second fetch, then becomes 99. No other word changes.
3. frame_start pulses in cycles 4 and 13 of a fetch.
   -> Exactly one frame_done occurs. overrun=1 and stays 1. A later frame_start while IDLE fetches normally.
4. Assert reset in cycle 5 of a fetch.
   -> busy, mem_rd_en and coords go to 0 immediately, without a clock edge.
   -> After reset is released, frame_start restarts the fetch at address 6000.
5. Set READ_LATENCY=3 and feed data through a 3-cycle delay model.
   -> REQ occurs in cycles 1, 5, 9, 13, 17, 21. frame_done occurs in cycle 25. coords are correct.
6. Set word0=700 and word1=500.
   -> With SPRITE_FETCH_CLAMP_EN defined: coords word0=639, word1=479.
   -> Without the macro: coords word0=700, word1=500.

Source files
------------

// File: rtl/sprite_fetch_if.sv
// ---------------------------------------------------------------------------
// sprite_fetch_if
//
// Bundles the signals between the sprite fetch scheduler, the VGA read port
// (port A) of basic_mem and the vga block.
//
//   frame_start : single-cycle pulse at vblank start (vga -> scheduler)
//   mem_addr    : port A read address               (scheduler -> mem)
//   mem_rd_en   : one-cycle read issue strobe        (scheduler -> mem)
//   mem_data    : port A read data                   (mem -> scheduler)
//   coords      : committed coordinate words; word k at [k*WIDTH +: WIDTH]
//   busy        : fetch in progress
//   frame_done  : one-cycle pulse when a frame is committed
//   overrun     : sticky, frame_start arrived while a fetch was running
//
// Modports:
//   master : the scheduler side
//   slave  : the environment side (memory + vga)
// ---------------------------------------------------------------------------
interface sprite_fetch_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 16,
    parameter int NUM_WORDS = 6
);
    logic                       frame_start;
    logic [ADDR_BITS-1:0]       mem_addr;
    logic                       mem_rd_en;
    logic [WIDTH-1:0]           mem_data;
    logic [NUM_WORDS*WIDTH-1:0] coords;
    logic                       busy;
    logic                       frame_done;
    logic                       overrun;

    modport master (
        input  frame_start,
        input  mem_data,
        output mem_addr,
        output mem_rd_en,
        output coords,
        output busy,
        output frame_done,
        output overrun
    );

    modport slave (
        output frame_start,
        output mem_data,
        input  mem_addr,
        input  mem_rd_en,
        input  coords,
        input  busy,
        input  frame_done,
        input  overrun
    );
endinterface

// File: rtl/sprite_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_fetch_scheduler
//
// On a vblank-start pulse, walks NUM_WORDS coordinate words (mx, my, p1x,
// p1y, p2x, p2y) out of basic_mem port A at BASE_ADDR + idx*ADDR_STRIDE,
// captures each into a shadow register, and then commits the whole set to
// the coords outputs on one clock edge so vga never sees a torn frame.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset (clears committed coords too)
//   bus    : sprite_fetch_if.master
//              frame_start, mem_data                 (inputs)
//              mem_addr, mem_rd_en, coords,
//              busy, frame_done, overrun             (outputs)
//
// Optional feature (compile-time macro SPRITE_FETCH_CLAMP_EN):
//   When defined, each captured word is treated as unsigned and saturated
//   before it reaches the shadow register: X words (even idx) to H_RES-1,
//   Y words (odd idx) to V_RES-1. When undefined, raw data is stored.
// ---------------------------------------------------------------------------
module sprite_fetch_scheduler #(
    parameter int WIDTH        = 16,
    parameter int ADDR_BITS    = 16,
    parameter int NUM_WORDS    = 6,
    parameter int BASE_ADDR    = 6000,
    parameter int ADDR_STRIDE  = 4,
    parameter int READ_LATENCY = 1,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480
) (
    input  logic           clk,
    input  logic           reset,
    sprite_fetch_if.master bus
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    // WAIT holds READ_LATENCY-1 cycles; the counter is loaded with
    // READ_LATENCY-2 and exits on zero, so it must represent READ_LATENCY-2.
    localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

    // Elaboration-time sanity checks on the configuration.
    generate
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("sprite_fetch_scheduler: READ_LATENCY must be >= 1");
        end
        if (NUM_WORDS < 1) begin : g_bad_words
            $error("sprite_fetch_scheduler: NUM_WORDS must be >= 1");
        end
        if (H_RES < 1 || V_RES < 1) begin : g_bad_res
            $error("sprite_fetch_scheduler: H_RES and V_RES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]                idx;
    logic [CNT_W-1:0]                wait_cnt;
    logic [NUM_WORDS-1:0][WIDTH-1:0] shadow;
    logic [NUM_WORDS-1:0][WIDTH-1:0] coords_q;
    logic                            overrun_q;
    logic [WIDTH-1:0]                capture_word;

`ifdef SPRITE_FETCH_CLAMP_EN
    // Unsigned saturation of one coordinate word to the visible area.
    function automatic logic [WIDTH-1:0] clamp_coord(
        input logic [WIDTH-1:0] raw,
        input logic             is_y
    );
        logic [WIDTH-1:0] limit;
        limit = is_y ? WIDTH'(V_RES - 1) : WIDTH'(H_RES - 1);
        return (raw > limit) ? limit : raw;
    endfunction

    // Word order alternates X, Y, so idx[0] selects the Y limit.
    assign capture_word = clamp_coord(bus.mem_data, idx[0]);
`else
    assign capture_word = bus.mem_data;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // With single-cycle memory the data is already due in the
                // next cycle, so WAIT is skipped entirely.
                state_d = (READ_LATENCY > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = (idx == LAST_IDX) ? S_COMMIT : S_REQ;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Index, latency counter, shadow capture and atomic commit
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            wait_cnt  <= '0;
            shadow    <= '0;
            coords_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            // Any start request outside IDLE is dropped and remembered;
            // this also covers a frame_start held high past the first cycle.
            if (bus.frame_start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_REQ: begin
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    shadow[idx] <= capture_word;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // All words move on this single edge, so vga never sees
                    // a mix of old and new coordinates.
                    coords_q <= shadow;
                    idx      <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them without a clock edge
    // -----------------------------------------------------------------------
    assign bus.mem_addr   = ADDR_BITS'(BASE_ADDR + ADDR_STRIDE * int'(idx));
    assign bus.mem_rd_en  = (state_q == S_REQ);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = (state_q == S_COMMIT);
    assign bus.coords     = coords_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
`timescale 1ns/1ps
module tb_sprite_fetch_scheduler;

    localparam int W  = 16;
    localparam int AB = 16;
    localparam int NW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        fs1;
    logic        fs3;
    logic [15:0] mem1 [0:5];
    logic [15:0] mem3 [0:5];
    logic [15:0] rdata1;
    logic [15:0] d3_0;
    logic [15:0] d3_1;
    logic [15:0] d3_2;

    logic [95:0] exp1;
    logic [95:0] exp2;
    logic [95:0] exp3;
    logic [95:0] exp6;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_fetch_if #(.WIDTH(W), .ADDR_BITS(AB), .NUM_WORDS(NW)) bus1 ();
    sprite_fetch_if #(.WIDTH(W), .ADDR_BITS(AB), .NUM_WORDS(NW)) bus3 ();

    sprite_fetch_scheduler #(
        .WIDTH(W), .ADDR_BITS(AB), .NUM_WORDS(NW), .BASE_ADDR(6000),
        .ADDR_STRIDE(4), .READ_LATENCY(1), .H_RES(640), .V_RES(480)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    sprite_fetch_scheduler #(
        .WIDTH(W), .ADDR_BITS(AB), .NUM_WORDS(NW), .BASE_ADDR(6000),
        .ADDR_STRIDE(4), .READ_LATENCY(3), .H_RES(640), .V_RES(480)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    assign bus1.frame_start = fs1;
    assign bus1.mem_data    = rdata1;
    assign bus3.frame_start = fs3;
    assign bus3.mem_data    = d3_2;

    // Sparse memory: only the six coordinate addresses hold data.
    function automatic logic [15:0] lookup(input logic sel3, input logic [15:0] a);
        int off;
        off = int'(a) - 6000;
        if (off < 0 || off > 20 || (off % 4) != 0) return 16'hDEAD;
        return sel3 ? mem3[off / 4] : mem1[off / 4];
    endfunction

    // Read data is valid for exactly one cycle, READ_LATENCY cycles after the
    // issue cycle; every other cycle carries a junk marker.
    always @(posedge clk) begin
        rdata1 <= bus1.mem_rd_en ? lookup(1'b0, bus1.mem_addr) : 16'hBAD0;
        d3_0   <= bus3.mem_rd_en ? lookup(1'b1, bus3.mem_addr) : 16'hBAD0;
        d3_1   <= d3_0;
        d3_2   <= d3_1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        rd_en;
        logic [15:0] addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [15];

    // Pulse frame_start for one cycle; returns in cycle 1 (first REQ).
    task automatic start1();
        @(negedge clk); fs1 = 1'b1;
        @(negedge clk); fs1 = 1'b0;
    endtask

    task automatic start3();
        @(negedge clk); fs3 = 1'b1;
        @(negedge clk); fs3 = 1'b0;
    endtask

    // One full latency-1 fetch checked cycle by cycle against the table.
    task automatic run_table(input string tag, input logic [95:0] old_c, input logic [95:0] new_c);
        start1();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("%s c%0d rd_en", tag, tbl[i].cyc), bus1.mem_rd_en, tbl[i].rd_en);
            check($sformatf("%s c%0d addr", tag, tbl[i].cyc), bus1.mem_addr, tbl[i].addr);
            check($sformatf("%s c%0d busy", tag, tbl[i].cyc), bus1.busy, tbl[i].busy);
            check($sformatf("%s c%0d frame_done", tag, tbl[i].cyc), bus1.frame_done, tbl[i].done);
            check($sformatf("%s c%0d coords", tag, tbl[i].cyc), bus1.coords,
                  (tbl[i].cyc >= 14) ? new_c : old_c);
            @(negedge clk);
        end
    endtask

    initial begin
        int done_cnt;
        logic exp_rd;

        tbl[0]  = '{1,  1'b1, 16'd6000, 1'b1, 1'b0};
        tbl[1]  = '{2,  1'b0, 16'd6000, 1'b1, 1'b0};
        tbl[2]  = '{3,  1'b1, 16'd6004, 1'b1, 1'b0};
        tbl[3]  = '{4,  1'b0, 16'd6004, 1'b1, 1'b0};
        tbl[4]  = '{5,  1'b1, 16'd6008, 1'b1, 1'b0};
        tbl[5]  = '{6,  1'b0, 16'd6008, 1'b1, 1'b0};
        tbl[6]  = '{7,  1'b1, 16'd6012, 1'b1, 1'b0};
        tbl[7]  = '{8,  1'b0, 16'd6012, 1'b1, 1'b0};
        tbl[8]  = '{9,  1'b1, 16'd6016, 1'b1, 1'b0};
        tbl[9]  = '{10, 1'b0, 16'd6016, 1'b1, 1'b0};
        tbl[10] = '{11, 1'b1, 16'd6020, 1'b1, 1'b0};
        tbl[11] = '{12, 1'b0, 16'd6020, 1'b1, 1'b0};
        tbl[12] = '{13, 1'b0, 16'd6020, 1'b1, 1'b1};
        tbl[13] = '{14, 1'b0, 16'd6000, 1'b0, 1'b0};
        tbl[14] = '{15, 1'b0, 16'd6000, 1'b0, 1'b0};

        mem1[0] = 16'd10; mem1[1] = 16'd20; mem1[2] = 16'd30;
        mem1[3] = 16'd40; mem1[4] = 16'd50; mem1[5] = 16'd60;
        mem3[0] = 16'd11; mem3[1] = 16'd22; mem3[2] = 16'd33;
        mem3[3] = 16'd44; mem3[4] = 16'd55; mem3[5] = 16'd66;

        exp1 = {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
        exp2 = {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd99};
        exp3 = {16'd66, 16'd55, 16'd44, 16'd33, 16'd22, 16'd11};
`ifdef SPRITE_FETCH_CLAMP_EN
        exp6 = {16'd60, 16'd50, 16'd40, 16'd30, 16'd479, 16'd639};
`else
        exp6 = {16'd60, 16'd50, 16'd40, 16'd30, 16'd500, 16'd700};
`endif

        // Reset state
        reset = 1'b1;
        fs1   = 1'b0;
        fs3   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst busy", bus1.busy, 1'b0);
        check("rst rd_en", bus1.mem_rd_en, 1'b0);
        check("rst frame_done", bus1.frame_done, 1'b0);
        check("rst overrun", bus1.overrun, 1'b0);
        check("rst coords", bus1.coords, 96'd0);
        check("rst addr", bus1.mem_addr, 16'd6000);
        check("rst busy3", bus3.busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: basic fetch and commit
        run_table("t1", 96'd0, exp1);
        check("t1 overrun", bus1.overrun, 1'b0);

        // Test 2: new word0 appears only at the commit of the second fetch
        mem1[0] = 16'd99;
        run_table("t2", exp1, exp2);

        // Test 3: frame_start during fetch and during COMMIT
        start1();
        done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 4)  fs1 = 1'b1;
            if (c == 5)  fs1 = 1'b0;
            if (c == 13) fs1 = 1'b1;
            if (c == 14) fs1 = 1'b0;
            if (c == 4) check("t3 overrun before", bus1.overrun, 1'b0);
            if (c == 5) check("t3 overrun after", bus1.overrun, 1'b1);
            if (c == 14) check("t3 no restart c14", bus1.busy, 1'b0);
            if (c == 15) check("t3 no restart c15", bus1.busy, 1'b0);
            if (bus1.frame_done) done_cnt++;
            @(negedge clk);
        end
        check("t3 frame_done count", done_cnt, 1);
        check("t3 overrun sticky", bus1.overrun, 1'b1);
        check("t3 coords", bus1.coords, exp2);
        run_table("t3b", exp2, exp2);
        check("t3b overrun sticky", bus1.overrun, 1'b1);

        // Test 4: asynchronous reset mid-fetch
        start1();
        repeat (4) @(negedge clk);
        check("t4 pre rd_en", bus1.mem_rd_en, 1'b1);
        check("t4 pre addr", bus1.mem_addr, 16'd6008);
        #1 reset = 1'b1;
        #1;
        check("t4 busy", bus1.busy, 1'b0);
        check("t4 rd_en", bus1.mem_rd_en, 1'b0);
        check("t4 frame_done", bus1.frame_done, 1'b0);
        check("t4 coords", bus1.coords, 96'd0);
        check("t4 overrun", bus1.overrun, 1'b0);
        check("t4 addr", bus1.mem_addr, 16'd6000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_table("t4r", 96'd0, exp2);

        // Test 5: READ_LATENCY = 3
        start3();
        for (int c = 1; c <= 26; c++) begin
            exp_rd = (c <= 21) && (((c - 1) % 4) == 0);
            check($sformatf("t5 c%0d rd_en", c), bus3.mem_rd_en, exp_rd);
            if (exp_rd)
                check($sformatf("t5 c%0d addr", c), bus3.mem_addr, 16'(6000 + 4 * ((c - 1) / 4)));
            check($sformatf("t5 c%0d frame_done", c), bus3.frame_done, c == 25);
            check($sformatf("t5 c%0d busy", c), bus3.busy, c <= 25);
            check($sformatf("t5 c%0d coords", c), bus3.coords, (c >= 26) ? exp3 : 96'd0);
            @(negedge clk);
        end

        // Test 6: out-of-range coordinates (clamped only with the macro)
        mem1[0] = 16'd700;
        mem1[1] = 16'd500;
        run_table("t6", exp2, exp6);
        check("t6 word0", bus1.coords[15:0], exp6[15:0]);
        check("t6 word1", bus1.coords[31:16], exp6[31:16]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
